// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: register map, STATUS/CTRL
// bit positions and the receive FSM state encoding.
package uart_pkg;

  // Word offsets on the peripheral bus
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;

  // STATUS bit positions (count lives in bits [7:4])
  localparam int STAT_VALID = 0;
  localparam int STAT_OVR   = 1;
  localparam int STAT_FERR  = 2;
  localparam int STAT_FULL  = 3;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_periph_if.sv
// Word-wide peripheral bus for the UART receiver.
// Access protocol: the master holds sel high for exactly one cycle per access;
// wren == 0 is a read, any set wren bit is a write. There is no ready/wait:
// every access completes on the clock edge where sel is high, and dout is
// combinational from adr and current register state.
interface uart_rx_periph_if;
  import uart_pkg::*;

  logic        sel;
  logic [3:0]  wren;
  logic [1:0]  adr;
  logic [31:0] di;
  logic [31:0] dout;
  logic        irq;
  rx_state_e   rx_state;  // receive FSM state, for debug observation

  modport master (output sel, wren, adr, di, input dout, irq, rx_state);
  modport slave  (input sel, wren, adr, di, output dout, irq, rx_state);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receive core: two-flop input synchroniser, bit-timing FSM and shift
// register. Emits a one-cycle strobe with the byte on a good stop bit, or a
// framing-error strobe on a bad one. Reusable for any UART instance.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       ferr_stb,
  output rx_state_e  state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  logic          sync1, rx_s;
  rx_state_e     state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;

  // Synchroniser; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // FSM state, bit counter, bit index and shift register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  // Next-state logic; the start bit is checked at its middle so later samples
  // land mid-bit, and a high there is treated as a glitch
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    byte_stb = 1'b0;
    ferr_stb = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = RX_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_n = '0;
          if (rx_s) begin
            byte_stb = 1'b1;
            state_n  = RX_IDLE;
          end else begin
            ferr_stb = 1'b1;
            state_n  = RX_BREAK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_BREAK: begin
        // Held-low line must return high before another frame can start
        if (rx_s) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_byte = sh;

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped UART receiver: receive core, byte FIFO, DATA/STATUS/CTRL
// registers and a registered level interrupt.
module uart_rx_periph
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             rx,
  uart_rx_periph_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_byte;
  logic        byte_stb, ferr_stb;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        full, empty;
  logic        rd_acc, wr_acc, pop, push, flush, ovr_set;
  logic        ovr, ferr, irq_en, irq_q;
  logic        clr_ovr, clr_ferr;
  logic [3:0]  cnt_sat;
  logic        unused_bits;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk      (clk),
    .n_reset  (n_reset),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .byte_stb (byte_stb),
    .ferr_stb (ferr_stb),
    .state    (bus.rx_state)
  );

  // Bus decode; a pop on a full FIFO frees the slot for a same-cycle push,
  // while a flush discards any push in its cycle
  always_comb begin
    full     = (count == (AW+1)'(FIFO_DEPTH));
    empty    = (count == '0);
    rd_acc   = bus.sel && (bus.wren == 4'd0);
    wr_acc   = bus.sel && bus.wren[0];
    pop      = rd_acc && (bus.adr == ADR_DATA) && !empty;
    flush    = wr_acc && (bus.adr == ADR_CTRL) && bus.di[CTRL_FLUSH];
    push     = byte_stb && !flush && (!full || pop);
    ovr_set  = byte_stb && !flush && full && !pop;
    clr_ovr  = wr_acc && (bus.adr == ADR_STATUS) && bus.di[STAT_OVR];
    clr_ferr = wr_acc && (bus.adr == ADR_STATUS) && bus.di[STAT_FERR];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // FIFO storage; contents are only visible through count, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  // Sticky flags (a new event beats a same-cycle clear), irq enable and irq
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ovr    <= 1'b0;
      ferr   <= 1'b0;
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ovr   <= ovr_set  | (ovr  & ~clr_ovr);
      ferr  <= ferr_stb | (ferr & ~clr_ferr);
      irq_q <= irq_en & (!empty | ovr | ferr);
      if (wr_acc && (bus.adr == ADR_CTRL)) irq_en <= bus.di[CTRL_IRQ_EN];
    end
  end

  // Read mux, combinational from adr
  always_comb begin
    cnt_sat  = (32'(count) > 32'd15) ? 4'd15 : 4'(count);
    bus.dout = '0;
    case (bus.adr)
      ADR_DATA:   bus.dout = {24'd0, empty ? 8'd0 : mem[rd_ptr]};
      ADR_STATUS: bus.dout = {24'd0, cnt_sat, full, ferr, ovr, !empty};
      ADR_CTRL:   bus.dout = {31'd0, irq_en};
      default:    bus.dout = '0;
    endcase
  end

  assign bus.irq     = irq_q;
  assign unused_bits = ^{bus.di[31:3], bus.wren[3:1]};

endmodule
